// File: rtl/exe_mem_stage.sv
// Execute-to-memory stage: passes ALU results through and runs single-outstanding
// load/store transactions on the data-memory port, producing one writeback beat per op.
module exe_mem_stage #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exe_mem,
    input  logic [127:0]      result,
    input  logic [63:0]       rflags,
    input  logic [1:0]        ex_op,
    input  logic [1:0]        ex_size,
    input  logic              ex_signed,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [3:0]        ex_dest,
    output logic              mem_blocked,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [1:0]        dmem_req_size,
    output logic [63:0]       dmem_req_data,
    input  logic              dmem_resp_valid,
    input  logic [63:0]       dmem_resp_data,
    output logic              wb_valid,
    output logic [3:0]        wb_dest,
    output logic [63:0]       wb_data,
    output logic [63:0]       wb_data_hi,
    output logic [63:0]       wb_rflags,
    output logic              wb_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_blocked;
    logic              r_req_valid;
    logic [63:0]       r_data;
    logic [63:0]       r_flags;
    logic [1:0]        r_op;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_dest;
    logic              r_wb_valid;
    logic [3:0]        r_wb_dest;
    logic [63:0]       r_wb_data;
    logic [63:0]       r_wb_hi;
    logic [63:0]       r_wb_flags;
    logic              r_wb_err;

    logic              w_accept;
    logic              w_is_mem;
    logic [63:0]       w_load_data;

    assign w_accept = exe_mem & ~r_blocked;
    assign w_is_mem = (ex_op == OP_LOAD) | (ex_op == OP_STORE);

    always_comb begin
        w_load_data = 64'd0;
        unique case (r_size)
            2'd0: w_load_data = {{56{r_signed & dmem_resp_data[7]}},
                                 dmem_resp_data[7:0]};
            2'd1: w_load_data = {{48{r_signed & dmem_resp_data[15]}},
                                 dmem_resp_data[15:0]};
            2'd2: w_load_data = {{32{r_signed & dmem_resp_data[31]}},
                                 dmem_resp_data[31:0]};
            default: w_load_data = dmem_resp_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_blocked   <= 1'b0;
            r_req_valid <= 1'b0;
            r_data      <= '0;
            r_flags     <= '0;
            r_op        <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_dest      <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_data   <= '0;
            r_wb_hi     <= '0;
            r_wb_flags  <= '0;
            r_wb_err    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data   <= result[63:0];
                        r_flags  <= rflags;
                        r_op     <= ex_op;
                        r_size   <= ex_size;
                        r_signed <= ex_signed;
                        r_addr   <= ex_addr;
                        r_dest   <= ex_dest;
                        if (w_is_mem) begin
                            r_state     <= S_REQ;
                            r_req_valid <= 1'b1;
                            r_blocked   <= 1'b1;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_dest  <= ex_dest;
                            r_wb_data  <= result[63:0];
                            r_wb_hi    <= result[127:64];
                            r_wb_flags <= rflags;
                            r_wb_err   <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response on the final counted cycle still wins over the abort.
                    if (dmem_resp_valid) begin
                        r_state    <= S_IDLE;
                        r_blocked  <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_dest  <= r_dest;
                        r_wb_data  <= (r_op == OP_LOAD) ? w_load_data : r_data;
                        r_wb_hi    <= '0;
                        r_wb_flags <= r_flags;
                        r_wb_err   <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= S_IDLE;
                        r_blocked  <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_dest  <= r_dest;
                        r_wb_data  <= '0;
                        r_wb_hi    <= '0;
                        r_wb_flags <= r_flags;
                        r_wb_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_blocked   <= 1'b0;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_blocked    = r_blocked;
    assign dmem_req_valid = r_req_valid;
    assign dmem_req_we    = (r_op == OP_STORE);
    assign dmem_req_addr  = r_addr;
    assign dmem_req_size  = r_size;
    assign dmem_req_data  = r_data;
    assign wb_valid       = r_wb_valid;
    assign wb_dest        = r_wb_dest;
    assign wb_data        = r_wb_data;
    assign wb_data_hi     = r_wb_hi;
    assign wb_rflags      = r_wb_flags;
    assign wb_err         = r_wb_err;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: random ops against a behavioural model,
// a memory responder process and a writeback monitor.
module tb_exe_mem_stage;

    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         exe_mem;
    logic [127:0] result;
    logic [63:0]  rflags;
    logic [1:0]   ex_op;
    logic [1:0]   ex_size;
    logic         ex_signed;
    logic [63:0]  ex_addr;
    logic [3:0]   ex_dest;
    logic         mem_blocked;
    logic         dmem_req_valid;
    logic         dmem_req_ready;
    logic         dmem_req_we;
    logic [63:0]  dmem_req_addr;
    logic [1:0]   dmem_req_size;
    logic [63:0]  dmem_req_data;
    logic         dmem_resp_valid;
    logic [63:0]  dmem_resp_data;
    logic         wb_valid;
    logic [3:0]   wb_dest;
    logic [63:0]  wb_data;
    logic [63:0]  wb_data_hi;
    logic [63:0]  wb_rflags;
    logic         wb_err;

    exe_mem_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .exe_mem(exe_mem), .result(result),
        .rflags(rflags), .ex_op(ex_op), .ex_size(ex_size),
        .ex_signed(ex_signed), .ex_addr(ex_addr), .ex_dest(ex_dest),
        .mem_blocked(mem_blocked), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr), .dmem_req_size(dmem_req_size),
        .dmem_req_data(dmem_req_data), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data(dmem_resp_data), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_data(wb_data), .wb_data_hi(wb_data_hi),
        .wb_rflags(wb_rflags), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dest;
        logic [63:0] data;
        logic [63:0] hi;
        logic [63:0] flags;
        logic        err;
    } wb_t;

    typedef struct {
        int          rd;
        int          pd;
        logic        we;
        logic [63:0] addr;
        logic [1:0]  sz;
        logic [63:0] data;
    } req_t;

    wb_t  exq[$];
    req_t rq[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm,
                         input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        if (a == 64'h1000) return 64'h0000_0000_0000_80FF;
        return {a[31:0] ^ 32'h9E37_79B9, a[31:0] * 32'd7 + 32'h8000_0080};
    endfunction

    // Load result from the size/sign rules, using masks instead of bit slices.
    function automatic logic [63:0] ref_load(input logic [63:0] d,
                                             input int sz, input bit sg);
        int bits;
        logic [63:0] mask;
        bits = 8 << sz;
        if (bits == 64) return d;
        mask = (64'd1 << bits) - 64'd1;
        if (sg && d[bits-1]) return (d & mask) | ~mask;
        return d & mask;
    endfunction

    // Writeback monitor
    always @(negedge clk) begin
        if (wb_valid) begin
            if (exq.size() == 0) begin
                check(1'b0, "wb_unexpected", wb_data, 64'd0);
            end else begin
                wb_t e;
                e = exq.pop_front();
                check(wb_data == e.data, "wb_data", wb_data, e.data);
                check(wb_data_hi == e.hi, "wb_data_hi", wb_data_hi, e.hi);
                check(wb_rflags == e.flags, "wb_rflags", wb_rflags, e.flags);
                check({wb_dest, wb_err} == {e.dest, e.err}, "wb_dest_err",
                      {59'd0, wb_dest, wb_err}, {59'd0, e.dest, e.err});
                if (e.err)
                    check(cyc - hs_cyc == TIMEOUT, "timeout_latency",
                          64'(cyc - hs_cyc), 64'(TIMEOUT));
            end
        end
    end

    // Data-memory responder
    initial begin
        req_t cur;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset_n && dmem_req_valid) begin
                if (rq.size() == 0) begin
                    check(1'b0, "req_unexpected", dmem_req_addr, 64'd0);
                    @(negedge clk);
                end else begin
                    cur = rq.pop_front();
                    check(dmem_req_addr == cur.addr, "req_addr",
                          dmem_req_addr, cur.addr);
                    check({dmem_req_we, dmem_req_size} == {cur.we, cur.sz},
                          "req_we_size", {61'd0, dmem_req_we, dmem_req_size},
                          {61'd0, cur.we, cur.sz});
                    check(dmem_req_data == cur.data, "req_data",
                          dmem_req_data, cur.data);
                    for (int i = 0; i < cur.rd; i++) begin
                        @(negedge clk);
                        check(dmem_req_valid && mem_blocked &&
                              dmem_req_addr == cur.addr &&
                              dmem_req_data == cur.data &&
                              dmem_req_size == cur.sz &&
                              dmem_req_we == cur.we, "req_hold",
                              dmem_req_data, cur.data);
                    end
                    dmem_req_ready = 1'b1;
                    @(negedge clk);
                    dmem_req_ready = 1'b0;
                    hs_cyc = cyc;
                    hs_cnt++;
                    check(!dmem_req_valid, "req_drop",
                          {63'd0, dmem_req_valid}, 64'd0);
                    repeat (cur.pd) @(negedge clk);
                    dmem_resp_valid = 1'b1;
                    dmem_resp_data  = mem_val(cur.addr);
                    @(negedge clk);
                    dmem_resp_valid = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] sz,
                         input bit sg, input logic [63:0] addr,
                         input logic [127:0] res, input logic [63:0] fl,
                         input logic [3:0] dest, input int rd, input int pd,
                         input bit exp_wb);
        int   g;
        bit   is_mem;
        wb_t  w;
        req_t r;
        g = 0;
        exe_mem = 1'b1; ex_op = op; ex_size = sz; ex_signed = sg;
        ex_addr = addr; result = res; rflags = fl; ex_dest = dest;
        while (mem_blocked && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (mem_blocked) begin
            check(1'b0, "accept_wait", 64'd1, 64'd0);
            exe_mem = 1'b0;
            return;
        end
        is_mem = (op == 2'd1) || (op == 2'd2);
        if (is_mem) begin
            r.rd = rd; r.pd = pd; r.we = (op == 2'd2); r.addr = addr;
            r.sz = sz; r.data = res[63:0];
            rq.push_back(r);
        end
        if (exp_wb) begin
            w.dest = dest; w.flags = fl; w.hi = '0; w.err = 1'b0;
            if (!is_mem) begin
                w.data = res[63:0];
                w.hi   = res[127:64];
            end else if (pd >= TIMEOUT) begin
                w.data = '0;
                w.err  = 1'b1;
            end else if (op == 2'd1) begin
                w.data = ref_load(mem_val(addr), int'(sz), sg);
            end else begin
                w.data = res[63:0];
            end
            exq.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        exe_mem = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int h0;
        reset_n = 1'b0;
        exe_mem = 1'b1; ex_op = 2'd0; ex_size = 2'd0; ex_signed = 1'b0;
        ex_addr = '0; result = 128'h1; rflags = 64'h11; ex_dest = 4'd1;
        repeat (2) begin
            @(negedge clk);
            check({mem_blocked, dmem_req_valid, dmem_req_we, wb_valid, wb_err} == 5'd0,
                  "reset_ctrl", {59'd0, mem_blocked, dmem_req_valid,
                  dmem_req_we, wb_valid, wb_err}, 64'd0);
            check((wb_data | wb_data_hi | wb_rflags | dmem_req_addr |
                   dmem_req_data | {58'd0, wb_dest, dmem_req_size}) == 64'd0,
                  "reset_data", wb_data | wb_data_hi | wb_rflags, 64'd0);
        end
        reset_n = 1'b1;

        // Back-to-back PASS burst, first op accepted right after reset
        for (int i = 1; i <= 4; i++) begin
            issue(2'd0, 2'd0, 1'b0, 64'd0, 128'(i) | (128'(i) << 64),
                  64'(i * 16), 4'(i), 0, 0, 1'b1);
            check(wb_valid && !mem_blocked, "pass_stream",
                  {62'd0, wb_valid, mem_blocked}, 64'd2);
        end
        idle(2);

        // Sized loads, signed then unsigned
        issue(2'd1, 2'd1, 1'b1, 64'h1000, 128'h5, 64'hA, 4'd5, 0, 0, 1'b1);
        issue(2'd1, 2'd1, 1'b0, 64'h1000, 128'h6, 64'hB, 4'd6, 0, 0, 1'b1);
        idle(6);

        // Store under back-pressure with a held PASS behind it
        issue(2'd2, 2'd2, 1'b0, 64'h2000, 128'hDEADBEEF, 64'hC, 4'd7,
              5, 0, 1'b1);
        issue(2'd0, 2'd0, 1'b0, 64'd0, 128'h77, 64'hD, 4'd8, 0, 0, 1'b1);
        idle(4);

        // Timeout with a late response
        issue(2'd1, 2'd3, 1'b0, 64'h3000, 128'h0, 64'hE, 4'd9, 0, 9, 1'b1);
        idle(16);

        // Reset while waiting for a response
        h0 = hs_cnt;
        issue(2'd1, 2'd0, 1'b1, 64'h4000, 128'h0, 64'hF, 4'd10, 0, 5, 1'b0);
        exe_mem = 1'b0;
        g = 0;
        while (hs_cnt == h0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check(hs_cnt != h0, "reset_test_hs", 64'(hs_cnt), 64'(h0 + 1));
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check({mem_blocked, dmem_req_valid, wb_valid} == 3'd0, "reset_abort",
              {61'd0, mem_blocked, dmem_req_valid, wb_valid}, 64'd0);
        idle(12);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            int pd;
            op = 2'($urandom_range(0, 3));
            pd = ($urandom_range(0, 9) == 9) ? 9 : int'($urandom_range(0, 3));
            issue(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  {32'd0, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), pd, 1'b1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        exe_mem = 1'b0;
        g = 0;
        while (exq.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        idle(14);
        check(exq.size() == 0, "scoreboard_drain", 64'(exq.size()), 64'd0);
        check(rq.size() == 0, "request_drain", 64'(rq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
